// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: ALU/load writeback requests and register-file write port bundle
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [15:0]           conflict_count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, reg_write, rd_address, write_data, conflict_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, reg_write, rd_address, write_data, conflict_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester writeback arbiter feeding one register-file write port.
// Optional feature macro WB_ROUND_ROBIN_EN: round-robin contention resolution
// (default build: load unit always wins contention, no round-robin state).
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  logic                  w_both;
  logic                  w_alu_grant;
  logic                  w_mem_grant;
  logic                  w_write;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_rd_address;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [15:0]           r_conflict_count;

  assign w_both = bus.alu_valid & bus.mem_valid;

`ifdef WB_ROUND_ROBIN_EN
  logic r_rr_alu;

  // ALU wins contention when the pointer favours it; a lone requester always wins
  assign w_alu_grant = !reset & bus.alu_valid & (!bus.mem_valid | r_rr_alu);

  // pointer flips only on contended cycles so the loser wins the next contention
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rr_alu <= 1'b1;
    else if (w_both) r_rr_alu <= !r_rr_alu;
  end
`else
  // load unit has fixed priority; ALU is granted only when uncontended
  assign w_alu_grant = !reset & bus.alu_valid & !bus.mem_valid;
`endif

  assign w_mem_grant   = !reset & bus.mem_valid & !w_alu_grant;
  assign w_write       = (w_alu_grant & (bus.alu_rd != '0)) | (w_mem_grant & (bus.mem_rd != '0));
  assign bus.alu_ready = w_alu_grant;
  assign bus.mem_ready = w_mem_grant;

  // register the granted request; writes to x0 are handshaken but suppressed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_rd_address <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_write;
      if (w_alu_grant) begin
        r_rd_address <= bus.alu_rd;
        r_write_data <= bus.alu_data;
      end else if (w_mem_grant) begin
        r_rd_address <= bus.mem_rd;
        r_write_data <= bus.mem_data;
      end
    end
  end

  // saturating count of cycles with both requesters valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_conflict_count <= '0;
    else if (w_both && r_conflict_count != 16'hFFFF) r_conflict_count <= r_conflict_count + 16'd1;
  end

  assign bus.reg_write      = r_reg_write;
  assign bus.rd_address     = r_rd_address;
  assign bus.write_data     = r_write_data;
  assign bus.conflict_count = r_conflict_count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  regfile_write_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

`ifdef WB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 64'h33;
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.reg_write !== 1'b0 || bus.rd_address !== 5'd0 || bus.write_data !== 64'd0 || bus.conflict_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b rd=%0d data=%0h cnt=%0d required all 0", bus.reg_write, bus.rd_address, bus.write_data, bus.conflict_count);
    end
    bus.alu_valid = 1'b1;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got alu_ready=%b mem_ready=%b required 0 0", bus.alu_ready, bus.mem_ready);
    end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 64'hA5;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_alu_ready: got alu=%b mem=%b required 1 0", bus.alu_ready, bus.mem_ready);
    end
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.rd_address !== 5'd5 || bus.write_data !== 64'hA5) begin
      errors++;
      $display("FAIL single_alu_write: got we=%b rd=%0d data=%0h required 1 5 a5", bus.reg_write, bus.rd_address, bus.write_data);
    end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.rd_address !== 5'd5 || bus.write_data !== 64'hA5) begin
      errors++;
      $display("FAIL idle_hold: got we=%b rd=%0d data=%0h required 0 5 a5", bus.reg_write, bus.rd_address, bus.write_data);
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp_alu;
    exp_alu = RR ? 3'b101 : 3'b000;
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 64'h33;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 64'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.alu_ready !== exp_alu[i] || bus.mem_ready !== !exp_alu[i]) begin
        errors++;
        $display("FAIL contention_grant%0d: got alu=%b mem=%b required %b %b", i, bus.alu_ready, bus.mem_ready, exp_alu[i], !exp_alu[i]);
      end
      tick();
      checks++;
      if (bus.reg_write !== 1'b1 || bus.rd_address !== (exp_alu[i] ? 5'd3 : 5'd7)) begin
        errors++;
        $display("FAIL contention_write%0d: got we=%b rd=%0d required 1 %0d", i, bus.reg_write, bus.rd_address, exp_alu[i] ? 3 : 7);
      end
    end
    idle();
    checks++;
    if (bus.conflict_count !== 16'd3) begin
      errors++;
      $display("FAIL conflict_count: got %0d required 3", bus.conflict_count);
    end
    tick();
    checks++;
    if (bus.conflict_count !== 16'd3) begin
      errors++;
      $display("FAIL conflict_count_hold: got %0d required 3", bus.conflict_count);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 64'hFF;
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_zero_ready: got mem=%b alu=%b required 1 0", bus.mem_ready, bus.alu_ready);
    end
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rd_zero_write: got we=%b required 0", bus.reg_write);
    end
  endtask

  task automatic test_same_rd();
    logic [63:0] first_d;
    logic [63:0] second_d;
    first_d  = RR ? 64'd1 : 64'd2;
    second_d = RR ? 64'd2 : 64'd1;
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 64'd1;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd9;
    bus.mem_data  = 64'd2;
    #1;
    checks++;
    if (bus.alu_ready !== RR || bus.mem_ready !== !RR) begin
      errors++;
      $display("FAIL same_rd_first: got alu=%b mem=%b required %b %b", bus.alu_ready, bus.mem_ready, RR, !RR);
    end
    tick();
    if (RR) bus.alu_valid = 1'b0;
    else bus.mem_valid = 1'b0;
    checks++;
    if (bus.reg_write !== 1'b1 || bus.rd_address !== 5'd9 || bus.write_data !== first_d) begin
      errors++;
      $display("FAIL same_rd_w1: got we=%b rd=%0d data=%0h required 1 9 %0h", bus.reg_write, bus.rd_address, bus.write_data, first_d);
    end
    #1;
    checks++;
    if (bus.alu_ready !== !RR || bus.mem_ready !== RR) begin
      errors++;
      $display("FAIL same_rd_second: got alu=%b mem=%b required %b %b", bus.alu_ready, bus.mem_ready, !RR, RR);
    end
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.rd_address !== 5'd9 || bus.write_data !== second_d) begin
      errors++;
      $display("FAIL same_rd_w2: got we=%b rd=%0d data=%0h required 1 9 %0h", bus.reg_write, bus.rd_address, bus.write_data, second_d);
    end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.write_data !== second_d) begin
      errors++;
      $display("FAIL same_rd_final: got we=%b data=%0h required 0 %0h", bus.reg_write, bus.write_data, second_d);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      idle();
      if (i % 2 == 1) begin
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'(i);
        bus.mem_data  = 64'(i * 17);
      end else begin
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'(i);
        bus.alu_data  = 64'(i * 17);
      end
      tick();
      checks++;
      if (bus.reg_write !== 1'b1 || bus.rd_address !== 5'(i) || bus.write_data !== 64'(i * 17)) begin
        errors++;
        $display("FAIL b2b_%0d: got we=%b rd=%0d data=%0h required 1 %0d %0h", i, bus.reg_write, bus.rd_address, bus.write_data, i, i * 17);
      end
    end
    idle();
    tick();
    checks++;
    if (bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got we=%b required 0", bus.reg_write);
    end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = 64'h10;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd2;
    bus.mem_data  = 64'h20;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    bus.mem_valid = 1'b1;
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_uncontended: got mem=%b alu=%b required 1 0", bus.mem_ready, bus.alu_ready);
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 64'h44;
    tick();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.rd_address !== 5'd4) begin
      errors++;
      $display("FAIL midflight_pre: got we=%b rd=%0d required 1 4", bus.reg_write, bus.rd_address);
    end
    idle();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd6;
    bus.mem_data  = 64'h66;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.reg_write !== 1'b0 || bus.rd_address !== 5'd0 || bus.write_data !== 64'd0 || bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL midflight_async: got we=%b rd=%0d data=%0h mem_ready=%b required 0 0 0 0", bus.reg_write, bus.rd_address, bus.write_data, bus.mem_ready);
    end
    idle();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.rd_address !== 5'd0) begin
      errors++;
      $display("FAIL midflight_release: got we=%b rd=%0d required 0 0", bus.reg_write, bus.rd_address);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd2;
    repeat (65534) tick();
    checks++;
    if (bus.conflict_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: got %0h required fffe", bus.conflict_count);
    end
    tick();
    checks++;
    if (bus.conflict_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %0h required ffff", bus.conflict_count);
    end
    repeat (5) tick();
    checks++;
    if (bus.conflict_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %0h required ffff", bus.conflict_count);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_single_alu();
    test_contention();
    test_rd_zero();
    test_same_rd();
    test_back_to_back();
    test_rr_pointer();
    test_reset_midflight();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
